// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, instruction} buffer between fetch and decode.
// Push/pop use valid/ready handshakes. The status outputs depend only on
// registered state, and full versus empty is tracked by an explicit count.
// A flush empties the queue on a control-flow redirect.
module fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc_plus4,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Entry storage; contents are meaningless until written, so no reset.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push;
  logic pop;
  logic wr_en;

  // Handshakes are qualified by registered status only, so a full queue
  // refuses a push even in a cycle where it also pops.
  always_comb begin
    in_ready  = (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wr_en     = push && !flush;
  end

  // Next-state for pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  // Control state register; reset drops every entry immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Write the accepted pair at the tail; a flushed push is dropped.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
    end
  end

  // Head read is combinational; an empty queue presents the reset pc and a NOP.
  always_comb begin
    out_pc    = RESET_PC;
    out_instr = NOP_INSTR;
    if (count_q != '0) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
    end
    out_pc_plus4 = out_pc + 32'd4;
    count        = count_q;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: linear stimulus, immediate-assertion checks.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  fetch_queue #(.DEPTH(4), .RESET_PC(32'hBFC00000), .NOP_INSTR(32'h00000013)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_pc_plus4 (out_pc_plus4),
    .out_instr    (out_instr),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-14s observed=%08h expected=%08h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_only(input logic [31:0] pc, input logic [31:0] instr);
    in_valid = 1'b1; in_pc = pc; in_instr = instr;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_pc", out_pc, 32'hBFC00000);
    check("rst_pc4", out_pc_plus4, 32'hBFC00004);
    check("rst_instr", out_instr, 32'h00000013);
    check("rst_count", 32'(count), 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    // Basic pass-through
    out_ready = 1'b1;
    push_only(32'hBFC00000, 32'h00500093);
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_pc", out_pc, 32'hBFC00000);
    check("pt_pc4", out_pc_plus4, 32'hBFC00004);
    check("pt_instr", out_instr, 32'h00500093);
    check("pt_count", 32'(count), 32'd1);
    step();
    check("pt_count0", 32'(count), 32'd0);
    check("pt_nop", out_instr, 32'h00000013);
    out_ready = 1'b0;

    // Fill and backpressure
    for (int i = 0; i < 4; i++) push_only(32'hBFC00000 + 32'(4 * i), 32'h100 + 32'(i));
    check("full_ready", 32'(in_ready), 32'd0);
    check("full_count", 32'(count), 32'd4);
    in_valid = 1'b1; in_pc = 32'hBFC00010; in_instr = 32'h104;
    step();
    check("held_count", 32'(count), 32'd4);
    check("held_head", out_pc, 32'hBFC00000);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop1_count", 32'(count), 32'd3);
    check("pop1_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("accept5", 32'(count), 32'd4);
    out_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("order_pc", out_pc, 32'hBFC00000 + 32'(4 * i));
      check("order_instr", out_instr, 32'h100 + 32'(i));
      step();
    end
    out_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);

    // Simultaneous push/pop at count 2 across pointer wrap
    push_only(32'h00001000, 32'hA0);
    push_only(32'h00001004, 32'hA1);
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_pc = 32'h00001008 + 32'(4 * k);
      in_instr = 32'hA2 + 32'(k);
      check("pp_head", out_pc, 32'h00001000 + 32'(4 * k));
      check("pp_count", 32'(count), 32'd2);
      step();
    end
    in_valid = 1'b0;
    check("pp_tail0", out_pc, 32'h00001028);
    check("pp_tail0i", out_instr, 32'hAA);
    step();
    check("pp_tail1", out_pc, 32'h0000102C);
    step();
    out_ready = 1'b0;
    check("pp_empty", 32'(count), 32'd0);

    // Flush with concurrent push and pop at count 3
    for (int i = 0; i < 3; i++) push_only(32'hBFC00000 + 32'(4 * i), 32'h200 + 32'(i));
    check("fl_pre", 32'(count), 32'd3);
    in_valid = 1'b1; in_pc = 32'hBFC0000C; in_instr = 32'h203;
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("fl_count", 32'(count), 32'd0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_pc", out_pc, 32'hBFC00000);
    push_only(32'hBFC00100, 32'h0000006F);
    check("fl_next_pc", out_pc, 32'hBFC00100);
    check("fl_next_ins", out_instr, 32'h0000006F);
    check("fl_next_cnt", 32'(count), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Asynchronous reset between edges
    for (int i = 0; i < 3; i++) push_only(32'h00003000 + 32'(4 * i), 32'h300 + 32'(i));
    check("ar_pre", 32'(count), 32'd3);
    #2; rst = 1'b0; #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_ready", 32'(in_ready), 32'd1);
    check("ar_count", 32'(count), 32'd0);
    check("ar_instr", out_instr, 32'h00000013);
    #1; rst = 1'b1;
    push_only(32'h00002000, 32'h000000AB);
    check("ar_pc", out_pc, 32'h00002000);
    check("ar_cnt", 32'(count), 32'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("ar_empty", 32'(count), 32'd0);

    // pc + 4 wraps modulo 2^32
    push_only(32'hFFFFFFFC, 32'h00000013);
    check("wrap_pc", out_pc, 32'hFFFFFFFC);
    check("wrap_pc4", out_pc_plus4, 32'h00000000);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // Flush while empty leaves the queue empty and ready
    flush = 1'b1; step(); flush = 1'b0;
    check("fe_count", 32'(count), 32'd0);
    check("fe_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
